// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared widths and state encoding for the factorial requester
package fact_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int FACT_N_W   = 4;
  localparam int FACT_NF_W  = 32;
  localparam int FACT_MAX_N = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } req_state_e;

endpackage

// File: rtl/fact_wdog.sv
// rtl/fact_wdog.sv - clear/enable saturating watchdog with expiry flag
module fact_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Flags the enabled cycle whose increment makes the count reach TIMEOUT_CYCLES.
  assign o_expired = i_en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/fact_requester.sv
// rtl/fact_requester.sv - issues one factorial request at a time and returns the result
module fact_requester
  import fact_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int N_W            = FACT_N_W,
  parameter int NF_W           = FACT_NF_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N_W-1:0]  req_n,
  output logic            fact_go,
  output logic [N_W-1:0]  fact_n,
  input  logic            fact_done,
  input  logic            fact_err,
  input  logic [NF_W-1:0] fact_nf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N_W-1:0]  rsp_n,
  output logic [NF_W-1:0] rsp_data,
  output logic            rsp_err,
  output logic            rsp_timeout
);

  req_state_e      r_state;
  logic            r_go;
  logic [N_W-1:0]  r_n;
  logic            r_valid;
  logic [NF_W-1:0] r_data;
  logic            r_err;
  logic            r_timeout;

  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;

  assign w_wd_clr = (r_state == ST_ISSUE);
  assign w_wd_en  = (r_state == ST_WAIT);

  fact_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_go      <= 1'b0;
      r_n       <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_n     <= req_n;
            r_go    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        // Done/Err may still be asserted from the previous run here, so they are not looked at.
        ST_ISSUE: begin
          r_go    <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fact_err) begin
            r_data    <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= ST_RESP;
          end else if (fact_done) begin
            r_data    <= fact_nf;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= ST_RESP;
          end else if (w_wd_expired) begin
            r_data    <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE) && !RST;
  assign fact_go     = r_go;
  assign fact_n      = r_n;
  assign rsp_valid   = r_valid;
  assign rsp_n       = r_n;
  assign rsp_data    = r_data;
  assign rsp_err     = r_err;
  assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_fact_requester.sv
// tb/tb_fact_requester.sv - self-checking bench for fact_requester with a behavioural engine
module tb_fact_requester;
  import fact_pkg::*;

  localparam int TO = 64;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_n = '0;
  logic        fact_go;
  logic [3:0]  fact_n;
  logic        fact_done;
  logic        fact_err;
  logic [31:0] fact_nf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [3:0]  rsp_n;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  fact_requester #(
    .TIMEOUT_CYCLES(TO),
    .N_W(4),
    .NF_W(32)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .fact_go(fact_go), .fact_n(fact_n),
    .fact_done(fact_done), .fact_err(fact_err), .fact_nf(fact_nf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact_of(input int n);
    longint r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r[31:0];
  endfunction

  // Behavioural engine: n+2 cycles of work after Go, Done/Err held as levels until the next Go.
  bit         eng_silent = 1'b0;
  logic       eng_busy;
  logic [3:0] eng_n;
  int         eng_cnt;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      fact_done <= 1'b0;
      fact_err  <= 1'b0;
      fact_nf   <= '0;
      eng_busy  <= 1'b0;
      eng_n     <= '0;
      eng_cnt   <= 0;
    end else if (fact_go) begin
      fact_done <= 1'b0;
      fact_err  <= 1'b0;
      eng_busy  <= 1'b1;
      eng_n     <= fact_n;
      eng_cnt   <= int'(fact_n) + 2;
    end else if (eng_busy && !eng_silent) begin
      if (eng_cnt == 0) begin
        eng_busy <= 1'b0;
        if (int'(eng_n) > FACT_MAX_N) begin
          fact_err  <= 1'b1;
          fact_done <= 1'b1;
          fact_nf   <= 32'hDEADBEEF;
        end else begin
          fact_done <= 1'b1;
          fact_nf   <= fact_of(int'(eng_n));
        end
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  function automatic exp_t expect_for(input logic [3:0] n);
    exp_t e;
    e.n = n;
    if (eng_silent) begin
      e.data = 0; e.err = 1'b1; e.to = 1'b1;
    end else if (int'(n) > FACT_MAX_N) begin
      e.data = 0; e.err = 1'b1; e.to = 1'b0;
    end else begin
      e.data = fact_of(int'(n)); e.err = 1'b0; e.to = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard compare process: samples on the falling edge.
  exp_t        sb[$];
  exp_t        e_pop;
  int          cyc = 0;
  int          go_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_go = 1'b0;
  logic        prev_de = 1'b0;
  logic [3:0]  p_n;
  logic [31:0] p_data;
  logic        p_err;
  logic        p_to;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      sb.delete();
      prev_valid = 1'b0;
      prev_go    = 1'b0;
      prev_de    = 1'b0;
    end else begin
      if (fact_go) begin
        check("go_single_pulse", prev_go, 0);
        go_cyc = cyc;
      end
      if (sb.size() > 0 && !rsp_valid) check("fact_n_hold", fact_n, sb[0].n);
      if (rsp_valid) begin
        check("req_ready_low_in_resp", req_ready, 0);
        if (prev_valid) begin
          check("rsp_n_stable", rsp_n, p_n);
          check("rsp_data_stable", rsp_data, p_data);
          check("rsp_err_stable", rsp_err, p_err);
          check("rsp_timeout_stable", rsp_timeout, p_to);
        end else if (sb.size() > 0) begin
          if (sb[0].to) check("timeout_latency", cyc - go_cyc, TO + 1);
          else          check("rsp_after_done_err", prev_de, 1);
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rsp_n=%0d expected no response", rsp_n);
          end else begin
            e_pop = sb.pop_front();
            check("rsp_n", rsp_n, e_pop.n);
            check("rsp_data", rsp_data, e_pop.data);
            check("rsp_err", rsp_err, e_pop.err);
            check("rsp_timeout", rsp_timeout, e_pop.to);
          end
        end
      end
      if (req_valid && req_ready) sb.push_back(expect_for(req_n));
      prev_valid = rsp_valid;
      prev_go    = fact_go;
      prev_de    = fact_done | fact_err;
      p_n    = rsp_n;
      p_data = rsp_data;
      p_err  = rsp_err;
      p_to   = rsp_timeout;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 300) begin
      @(posedge CLK); #1; k++;
    end
    check("req_ready_seen", req_ready, 1);
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (!rsp_valid && k < 300) begin
      @(posedge CLK); #1; k++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic do_req(input logic [3:0] n, output exp_t got);
    wait_ready();
    req_valid = 1'b1;
    req_n     = n;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    wait_rsp();
    got.n    = rsp_n;
    got.data = rsp_data;
    got.err  = rsp_err;
    got.to   = rsp_timeout;
    @(posedge CLK); #1;
  endtask

  exp_t r;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_fact_go", fact_go, 0);
    check("rst_fact_n", fact_n, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    RST = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);

    do_req(4'd5, r);
    check("t1_data", r.data, 120);
    check("t1_err", r.err, 0);
    check("t1_n", r.n, 5);

    do_req(4'd12, r);
    check("t2_data12", r.data, 32'h1C8CFC00);
    do_req(4'd0, r);
    check("t2_data0", r.data, 1);
    do_req(4'd1, r);
    check("t2_data1", r.data, 1);

    do_req(4'd13, r);
    check("t3_err", r.err, 1);
    check("t3_timeout", r.to, 0);
    check("t3_data", r.data, 0);
    do_req(4'd3, r);
    check("t3_recover", r.data, 6);

    // Backpressure with a request held on the upstream port.
    rsp_ready = 1'b0;
    wait_ready();
    req_valid = 1'b1;
    req_n     = 4'd6;
    @(posedge CLK); #1;
    req_n = 4'd2;
    wait_rsp();
    check("t4_data", rsp_data, 720);
    repeat (10) begin
      @(posedge CLK); #1;
      check("t4_held_valid", rsp_valid, 1);
      check("t4_no_go", fact_go, 0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    check("t4_valid_dropped", rsp_valid, 0);
    check("t4_ready_back", req_ready, 1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("t4_next_go", fact_go, 1);
    wait_rsp();
    check("t4_next_data", rsp_data, 2);
    @(posedge CLK); #1;

    eng_silent = 1'b1;
    do_req(4'd9, r);
    check("t5_timeout", r.to, 1);
    check("t5_err", r.err, 1);
    check("t5_data", r.data, 0);
    eng_silent = 1'b0;

    wait_ready();
    req_valid = 1'b1;
    req_n     = 4'd7;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #3;
    check("t6_pre_fact_n", fact_n, 7);
    RST = 1'b1;
    #1;
    check("t6_fact_n", fact_n, 0);
    check("t6_fact_go", fact_go, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready", req_ready, 0);
    check("t6_rsp_n", rsp_n, 0);
    check("t6_rsp_err", rsp_err, 0);
    check("t6_rsp_timeout", rsp_timeout, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("t6_still_no_rsp", rsp_valid, 0);
    RST = 1'b0;
    repeat (15) begin
      @(posedge CLK); #1;
      check("t6_no_stale_rsp", rsp_valid, 0);
    end
    do_req(4'd4, r);
    check("t6_after_rst", r.data, 24);
    check("sb_drained", sb.size(), 0);

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL global_time_limit: got still running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
